histogram_builder: RTL and testbench

Builds the per-frame 256-bin intensity histogram that the cumulative-histogram/threshold stage consumes. It takes an 8-bit grey pixel stream and clears the histogram RAM at frame start. Each accepted pixel is counted with a pipelined read-modify-write into its bin, with forwarding so back-to-back pixels of the same bin are never lost. When the frame completes it emits a one-cycle done pulse that serves as the start strobe for the cumulative stage.

---
 rtl/histogram_pkg.sv | 18 +
 rtl/histogram_builder_if.sv | 30 +++
 rtl/histogram_rmw_pipe.sv | 73 +++++++
 rtl/histogram_builder.sv | 106 ++++++++++
 tb/tb_histogram_builder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/histogram_pkg.sv
// Shared types and sizing for the 256-bin intensity histogram builder.
package histogram_pkg;

  localparam int unsigned BIN_COUNT  = 256;
  localparam int unsigned BIN_W      = 8;
  localparam int unsigned WORD_SIZE  = 20;
  localparam int unsigned NUM_PIXELS = 384000;
  localparam int unsigned PIX_CNT_W  = 20;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/histogram_builder_if.sv
// Pixel stream, histogram RAM ports and frame status for histogram_builder.
interface histogram_builder_if
  import histogram_pkg::*;
#(
  parameter int unsigned WordSize = WORD_SIZE
);

  logic                 iFrameStart;
  logic                 iPixelValid;
  logic [BIN_W-1:0]     iPixel;
  logic                 oReady;
  logic [BIN_W-1:0]     oAddrRd;
  logic [WordSize-1:0]  iQ;
  logic [BIN_W-1:0]     oAddrWr;
  logic [WordSize-1:0]  oDataWr;
  logic                 oWE;
  logic [PIX_CNT_W-1:0] oPixelCount;
  logic                 oFrameDone;

  modport slave (
    input  iFrameStart, iPixelValid, iPixel, iQ,
    output oReady, oAddrRd, oAddrWr, oDataWr, oWE, oPixelCount, oFrameDone
  );

  modport master (
    output iFrameStart, iPixelValid, iPixel, iQ,
    input  oReady, oAddrRd, oAddrWr, oDataWr, oWE, oPixelCount, oFrameDone
  );

endinterface

// File: rtl/histogram_rmw_pipe.sv
// Read-modify-write pipeline for histogram bins: stage-1 register, two-deep write
// forwarding, saturating increment and the registered RAM write port.
module histogram_rmw_pipe
  import histogram_pkg::*;
#(
  parameter int unsigned WordSize = WORD_SIZE
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [BIN_W-1:0]    i_bin,
  input  logic [WordSize-1:0] i_q,
  output logic                o_we,
  output logic [BIN_W-1:0]    o_addr,
  output logic [WordSize-1:0] o_data
);

  logic                r_s1_valid;
  logic [BIN_W-1:0]    r_s1_bin;
  logic                r_w1_valid;
  logic [BIN_W-1:0]    r_w1_bin;
  logic [WordSize-1:0] r_w1_value;
  logic                r_w2_valid;
  logic [BIN_W-1:0]    r_w2_bin;
  logic [WordSize-1:0] r_w2_value;
  logic [WordSize-1:0] w_old;
  logic [WordSize-1:0] w_new;

  // RAM returns old data on read-during-write, so W1 (being written now) and
  // W2 (written last cycle) are both newer than iQ and must win.
  always_comb begin
    if (r_w1_valid && (r_w1_bin == r_s1_bin)) begin
      w_old = r_w1_value;
    end else if (r_w2_valid && (r_w2_bin == r_s1_bin)) begin
      w_old = r_w2_value;
    end else begin
      w_old = i_q;
    end
    w_new = (&w_old) ? w_old : w_old + WordSize'(1);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_s1_valid <= 1'b0;
      r_s1_bin   <= '0;
      r_w1_valid <= 1'b0;
      r_w1_bin   <= '0;
      r_w1_value <= '0;
      r_w2_valid <= 1'b0;
      r_w2_bin   <= '0;
      r_w2_value <= '0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
      r_w1_valid <= 1'b0;
      r_w2_valid <= 1'b0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_bin   <= i_bin;
      r_w1_valid <= r_s1_valid;
      r_w1_bin   <= r_s1_bin;
      r_w1_value <= w_new;
      r_w2_valid <= r_w1_valid;
      r_w2_bin   <= r_w1_bin;
      r_w2_value <= r_w1_value;
    end
  end

  assign o_we   = r_w1_valid;
  assign o_addr = r_w1_bin;
  assign o_data = r_w1_value;

endmodule

// File: rtl/histogram_builder.sv
// Per-frame histogram builder: clears the bin RAM, accumulates one pixel per cycle,
// drains the write pipeline and pulses frame-done for the cumulative stage.
module histogram_builder
  import histogram_pkg::*;
#(
  parameter int unsigned WordSize  = WORD_SIZE,
  parameter int unsigned NumPixels = NUM_PIXELS
) (
  input logic                iClk,
  input logic                iRst,
  histogram_builder_if.slave bus
);

  state_e               r_state;
  state_e               w_state_next;
  logic [BIN_W-1:0]     r_clr_addr;
  logic                 r_clr_we;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic                 r_drain_cnt;
  logic                 w_ready;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_clr_last;
  logic                 w_pipe_we;
  logic [BIN_W-1:0]     w_pipe_addr;
  logic [WordSize-1:0]  w_pipe_data;

  // A frame-start pulse overrides any transfer in the same cycle.
  assign w_ready    = (r_state == StAccum);
  assign w_xfer     = bus.iPixelValid & w_ready & ~bus.iFrameStart;
  assign w_last     = (r_pix_cnt == PIX_CNT_W'(NumPixels - 1));
  assign w_clr_last = (r_clr_addr == BIN_W'(BIN_COUNT - 1));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.iFrameStart) begin
      w_state_next = StClear;
    end else begin
      case (r_state)
        StIdle:  w_state_next = StIdle;
        StClear: if (w_clr_last) w_state_next = StAccum;
        StAccum: if (w_xfer && w_last) w_state_next = StDrain;
        StDrain: if (r_drain_cnt) w_state_next = StDone;
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_clr_we    <= 1'b0;
      r_clr_addr  <= '0;
      r_pix_cnt   <= '0;
      r_drain_cnt <= 1'b0;
    end else if (bus.iFrameStart) begin
      r_clr_we    <= 1'b1;
      r_clr_addr  <= '0;
      r_pix_cnt   <= '0;
      r_drain_cnt <= 1'b0;
    end else begin
      if (r_state == StClear) begin
        r_clr_we   <= ~w_clr_last;
        r_clr_addr <= w_clr_last ? r_clr_addr : r_clr_addr + BIN_W'(1);
      end
      if (w_xfer) begin
        r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
      end
      r_drain_cnt <= (r_state == StDrain) ? ~r_drain_cnt : 1'b0;
    end
  end

  histogram_rmw_pipe #(
    .WordSize (WordSize)
  ) u_rmw_pipe (
    .iClk    (iClk),
    .iRst    (iRst),
    .i_flush (bus.iFrameStart),
    .i_valid (w_xfer),
    .i_bin   (bus.iPixel),
    .i_q     (bus.iQ),
    .o_we    (w_pipe_we),
    .o_addr  (w_pipe_addr),
    .o_data  (w_pipe_data)
  );

  // Clear writes and pipeline writes never overlap; the clear register wins the port.
  always_comb begin
    bus.oReady      = w_ready;
    bus.oFrameDone  = (r_state == StDone);
    bus.oAddrRd     = bus.iPixel;
    bus.oWE         = r_clr_we | w_pipe_we;
    bus.oAddrWr     = r_clr_we ? r_clr_addr : w_pipe_addr;
    bus.oDataWr     = r_clr_we ? '0 : w_pipe_data;
    bus.oPixelCount = r_pix_cnt;
  end

endmodule

// File: tb/tb_histogram_builder.sv
// Randomized bench for histogram_builder: a bin-count model predicts every RAM write,
// oReady, oPixelCount and oFrameDone cycle by cycle, and the final RAM contents.
module tb_histogram_builder;

  localparam int unsigned WordSize  = 3;
  localparam int unsigned NumPixels = 24;
  localparam int          MaxVal    = (1 << WordSize) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [WordSize-1:0] ram [256];

  int          m_hist [256];
  bit          m_active = 1'b0;
  bit          m_ready;
  int          m_count = 0;
  int          m_start = 0;
  int          m_last = -1;
  logic [7:0]  m_pix;
  int          exp_wa [int];
  int          exp_wd [int];

  histogram_builder_if #(.WordSize(WordSize)) bus ();

  histogram_builder #(
    .WordSize  (WordSize),
    .NumPixels (NumPixels)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-clock RAM, read-during-write returns old data.
  always @(posedge clk) begin
    bus.iQ <= ram[bus.oAddrRd];
    if (bus.oWE) ram[bus.oAddrWr] <= bus.oDataWr;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: evaluated mid-cycle, once inputs for the cycle are stable.
  always @(negedge clk) begin
    if (rst) begin
      exp_wa.delete();
      exp_wd.delete();
      m_active = 1'b0;
      m_count  = 0;
      m_last   = -1;
    end else begin
      m_ready = m_active && (cyc >= m_start + 257) && (m_count < NumPixels);
      check_eq("ready", bus.oReady, m_ready);
      check_eq("frame_done", bus.oFrameDone, (m_last >= 0) && (cyc == m_last + 3));
      check_eq("pixel_count", bus.oPixelCount, m_count);
      check_eq("addr_rd", bus.oAddrRd, bus.iPixel);
      if (exp_wa.exists(cyc)) begin
        check_eq("we", bus.oWE, 1);
        check_eq("wr_addr", bus.oAddrWr, exp_wa[cyc]);
        check_eq("wr_data", bus.oDataWr, exp_wd[cyc]);
        exp_wa.delete(cyc);
        exp_wd.delete(cyc);
      end else begin
        check_eq("we_idle", bus.oWE, 0);
      end
      if (bus.iFrameStart) begin
        for (int k = 1; k <= 260; k++) begin
          if (exp_wa.exists(cyc + k)) begin
            exp_wa.delete(cyc + k);
            exp_wd.delete(cyc + k);
          end
        end
        for (int k = 0; k < 256; k++) begin
          exp_wa[cyc + 1 + k] = k;
          exp_wd[cyc + 1 + k] = 0;
          m_hist[k] = 0;
        end
        m_count  = 0;
        m_active = 1'b1;
        m_start  = cyc;
        m_last   = -1;
      end else if (bus.iPixelValid && m_ready) begin
        m_pix = bus.iPixel;
        m_hist[m_pix] = (m_hist[m_pix] >= MaxVal) ? MaxVal : m_hist[m_pix] + 1;
        exp_wa[cyc + 2] = int'(m_pix);
        exp_wd[cyc + 2] = m_hist[m_pix];
        m_count++;
        if (m_count == NumPixels) m_last = cyc;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Wait for oReady, offering junk pixels that must not be accepted meanwhile.
  task automatic wait_ready();
    int g = 0;
    while (!bus.oReady && g < 400) begin
      bus.iPixelValid = 1'($urandom_range(0, 1));
      bus.iPixel      = 8'($urandom);
      next_cycle();
      g++;
    end
    check_eq("ready_timeout", g < 400, 1);
  endtask

  // sc: 0 same bin, 1 two bins alternating, 2 one bin with gaps, 3 four bins, 4 any bin.
  task automatic drive_frame(input int sc, input int abort_at, input int clr_abort);
    int         idx = 0;
    int         j = 0;
    int         guard = 0;
    int         ab = abort_at;
    logic       v;
    logic [7:0] p;
    logic [7:0] set4 [4];
    logic [5:0] gap_pat = 6'b100101;
    for (int i = 0; i < 4; i++) set4[i] = 8'($urandom);
    bus.iPixelValid = 1'b0;
    bus.iFrameStart = 1'b1;
    next_cycle();
    bus.iFrameStart = 1'b0;
    if (clr_abort > 0) begin
      repeat (clr_abort) next_cycle();
      bus.iFrameStart = 1'b1;
      next_cycle();
      bus.iFrameStart = 1'b0;
    end
    wait_ready();
    while (idx < NumPixels && guard < 2000) begin
      case (sc)
        0:       begin v = 1'b1; p = set4[0]; end
        1:       begin v = 1'b1; p = set4[idx % 2]; end
        2:       begin v = gap_pat[j % 6]; p = set4[0]; end
        3:       begin v = ($urandom_range(0, 9) < 7); p = set4[$urandom_range(0, 3)]; end
        default: begin v = 1'($urandom_range(0, 1)); p = 8'($urandom); end
      endcase
      if (ab >= 0 && idx == ab) begin
        bus.iFrameStart = 1'b1;
        bus.iPixelValid = 1'b1;
        bus.iPixel      = p;
        next_cycle();
        bus.iFrameStart = 1'b0;
        bus.iPixelValid = 1'b0;
        ab  = -1;
        idx = 0;
        j   = 0;
        wait_ready();
      end else begin
        bus.iPixelValid = v;
        bus.iPixel      = p;
        if (v && bus.oReady) idx++;
        j++;
        guard++;
        next_cycle();
      end
    end
    check_eq("feed_timeout", idx, NumPixels);
    bus.iPixelValid = 1'b0;
    bus.iPixel      = 8'($urandom);
    guard = 0;
    while (!bus.oFrameDone && guard < 10) begin
      next_cycle();
      guard++;
    end
    check_eq("done_timeout", guard < 10, 1);
    check_eq("final_count", bus.oPixelCount, NumPixels);
    for (int b = 0; b < 256; b++) check_eq("ram_bin", ram[b], m_hist[b]);
    next_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iFrameStart = 1'b0;
    bus.iPixelValid = 1'b0;
    bus.iPixel      = 8'd0;
    for (int i = 0; i < 256; i++) ram[i] <= WordSize'($urandom);
    repeat (3) next_cycle();
    check_eq("rst_ready", bus.oReady, 0);
    check_eq("rst_we", bus.oWE, 0);
    check_eq("rst_addr_wr", bus.oAddrWr, 0);
    check_eq("rst_data_wr", bus.oDataWr, 0);
    check_eq("rst_count", bus.oPixelCount, 0);
    check_eq("rst_done", bus.oFrameDone, 0);
    rst = 1'b0;
    next_cycle();

    drive_frame(0, -1, 0);
    drive_frame(1, -1, 0);
    drive_frame(2, -1, 0);
    drive_frame(3, 10, 0);
    drive_frame(3, -1, 37);
    drive_frame(4, -1, 0);
    for (int r = 0; r < 4; r++) begin
      drive_frame($urandom_range(0, 4),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NumPixels - 1)) : -1,
                  0);
    end

    // Asynchronous reset in the middle of accumulation.
    bus.iFrameStart = 1'b1;
    next_cycle();
    bus.iFrameStart = 1'b0;
    wait_ready();
    bus.iPixelValid = 1'b1;
    bus.iPixel      = 8'd42;
    repeat (5) next_cycle();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ready", bus.oReady, 0);
    check_eq("arst_we", bus.oWE, 0);
    check_eq("arst_count", bus.oPixelCount, 0);
    check_eq("arst_addr_wr", bus.oAddrWr, 0);
    check_eq("arst_data_wr", bus.oDataWr, 0);
    bus.iPixelValid = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;
    next_cycle();
    drive_frame(3, -1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
